// File: rtl/ram_access_master_if.sv
// ram_access_master_if: core-side request/response handshake of the RAM access master.
interface ram_access_master_if #(parameter int ADDR_W = 13);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_access_master.sv
// ram_access_master: byte/half/word load-store initiator for a 1-port RAM with 1-cycle read latency.
module ram_access_master #(parameter int ADDR_W = 13) (
    input  logic              clock,
    input  logic              reset,
    ram_access_master_if.slave bus,
    output logic [ADDR_W-3:0] ram_address,
    output logic [3:0]        ram_byteena,
    output logic [31:0]       ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, RESP = 2'd2;
    logic [1:0]  r_state, r_off, r_size;
    logic        r_uns, r_rsp_valid, r_err;
    logic [31:0] r_rdata;
    logic        w_acc, w_err, w_load, w_store;
    logic [3:0]  w_be;
    logic [31:0] w_sh, w_ext;
    assign bus.req_ready = (r_state == IDLE) & !reset;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    always_comb begin
        w_acc   = bus.req_valid & bus.req_ready;
        w_err   = (bus.req_size == 2'b11) | ((bus.req_size == 2'b01) & bus.req_addr[0])
                | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));
        w_load  = w_acc & !bus.req_we & !w_err;
        w_store = w_acc & bus.req_we & !w_err;
        w_be    = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0]
                : bus.req_size == 2'b01 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
        ram_rden    = w_load;
        ram_wren    = w_store;
        ram_address = (w_load | w_store) ? bus.req_addr[ADDR_W-1:2] : '0;
        ram_byteena = (w_load | w_store) ? w_be : 4'b0000;
        ram_data    = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}}
                    : bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        // ram_q only reaches r_rdata on the READ->RESP edge
        w_sh  = ram_q >> {r_off, 3'b000};
        w_ext = r_size == 2'b00 ? {{24{!r_uns & w_sh[7]}}, w_sh[7:0]}
              : r_size == 2'b01 ? {{16{!r_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
        end else if (w_acc) begin
            r_off       <= bus.req_addr[1:0];
            r_size      <= bus.req_size;
            r_uns       <= bus.req_unsigned;
            r_state     <= w_load ? READ : RESP;
            r_rsp_valid <= !w_load;
            r_err       <= w_err;
            r_rdata     <= '0;
        end else if (r_state == READ) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_ext;
            r_err       <= 1'b0;
        end else if (r_state == RESP && bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
        end
    end
endmodule
